// File: rtl/keyword_command_fsm.sv
// Keyword command sequencer: arms on a wake word, issues the next valid keyword
// as a valid/ready command within a timeout window, and counts completed commands.
module keyword_command_fsm #(
   parameter logic [3:0]  SILENCE_ID     = 4'd0,
   parameter logic [3:0]  WAKE_ID        = 4'd1,
   parameter int unsigned NUM_KEYWORDS   = 10,
   parameter int unsigned TIMEOUT_CYCLES = 50000000,
   parameter int unsigned TMR_W          = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] keyword_in,
   input  logic       cmd_ready,
   output logic       cmd_valid,
   output logic [3:0] cmd_id,
   output logic       armed,
   output logic       timeout_pulse,
   output logic [7:0] event_count
);

   localparam int unsigned KW_W     = 4;
   localparam int unsigned KW_EXT_W = KW_W + 1;
   localparam int unsigned CNT_W    = 8;

   localparam logic [TMR_W-1:0]    TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [KW_EXT_W-1:0] NUM_KW   = KW_EXT_W'(NUM_KEYWORDS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_ISSUE = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [KW_W-1:0]    prev_kw;
   logic [TMR_W-1:0]   timer, timer_nxt;
   logic               cmd_valid_nxt;
   logic [KW_W-1:0]    cmd_id_nxt;
   logic               armed_nxt;
   logic               timeout_pulse_nxt;
   logic [CNT_W-1:0]   event_count_nxt;
   logic               kw_event_c;
   logic               is_wake_c;

   // A new, valid, non-silent keyword appeared on this cycle
   assign kw_event_c = (keyword_in != prev_kw) &&
                       (keyword_in != SILENCE_ID) &&
                       ({1'b0, keyword_in} < NUM_KW);
   assign is_wake_c  = (keyword_in == WAKE_ID);

   // Next-state and next-output logic
   always_comb begin
      state_nxt         = state;
      timer_nxt         = timer;
      cmd_valid_nxt     = cmd_valid;
      cmd_id_nxt        = cmd_id;
      timeout_pulse_nxt = 1'b0;
      event_count_nxt   = event_count;

      case (state)
         S_IDLE: begin
            if (kw_event_c && is_wake_c) begin
               state_nxt = S_ARMED;
               timer_nxt = TMR_LOAD;
            end
         end
         S_ARMED: begin
            // An event always beats an expiring timer
            if (kw_event_c) begin
               if (is_wake_c) begin
                  timer_nxt = TMR_LOAD;
               end else begin
                  cmd_id_nxt    = keyword_in;
                  cmd_valid_nxt = 1'b1;
                  state_nxt     = S_ISSUE;
               end
            end else if (timer == '0) begin
               state_nxt         = S_IDLE;
               timeout_pulse_nxt = 1'b1;
            end else begin
               timer_nxt = timer - TMR_W'(1);
            end
         end
         S_ISSUE: begin
            if (cmd_ready) begin
               cmd_valid_nxt   = 1'b0;
               event_count_nxt = event_count + CNT_W'(1);
               state_nxt       = S_IDLE;
            end
         end
         default: begin
            state_nxt     = S_IDLE;
            cmd_valid_nxt = 1'b0;
         end
      endcase

      armed_nxt = (state_nxt == S_ARMED);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= S_IDLE;
         prev_kw       <= SILENCE_ID;
         timer         <= '0;
         cmd_valid     <= 1'b0;
         cmd_id        <= '0;
         armed         <= 1'b0;
         timeout_pulse <= 1'b0;
         event_count   <= '0;
      end else begin
         state         <= state_nxt;
         prev_kw       <= keyword_in;
         timer         <= timer_nxt;
         cmd_valid     <= cmd_valid_nxt;
         cmd_id        <= cmd_id_nxt;
         armed         <= armed_nxt;
         timeout_pulse <= timeout_pulse_nxt;
         event_count   <= event_count_nxt;
      end
   end

endmodule

// File: tb/tb_keyword_command_fsm.sv
// Bench for keyword_command_fsm: directed scenarios with literal expectations plus
// randomized keyword/ready/reset traffic checked every cycle against a deadline-based model.
module tb_keyword_command_fsm;

   localparam int T = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] kw  = 4'd0;
   logic       rdy = 1'b0;
   logic       cmd_valid;
   logic [3:0] cmd_id;
   logic       armed;
   logic       timeout_pulse;
   logic [7:0] event_count;

   int errors = 0;
   int checks = 0;

   // Model: the window is an absolute edge deadline, the command a pending flag
   int         e_now      = 0;
   int         m_deadline = 0;
   bit         m_armed    = 1'b0;
   bit         m_pending  = 1'b0;
   bit         m_pulse    = 1'b0;
   logic [3:0] m_id       = 4'd0;
   logic [3:0] m_prev     = 4'd0;
   int         m_count    = 0;

   logic [3:0] bp_seq [10] = '{4'd5, 4'd5, 4'd0, 4'd0, 4'd1, 4'd1, 4'd7, 4'd7, 4'd7, 4'd7};

   always #5 clk = ~clk;

   keyword_command_fsm #(
      .SILENCE_ID    (4'd0),
      .WAKE_ID       (4'd1),
      .NUM_KEYWORDS  (10),
      .TIMEOUT_CYCLES(T),
      .TMR_W         (26)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .keyword_in   (kw),
      .cmd_ready    (rdy),
      .cmd_valid    (cmd_valid),
      .cmd_id       (cmd_id),
      .armed        (armed),
      .timeout_pulse(timeout_pulse),
      .event_count  (event_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit ev;
      e_now++;
      if (!rst) begin
         m_armed   = 1'b0;
         m_pending = 1'b0;
         m_pulse   = 1'b0;
         m_id      = 4'd0;
         m_prev    = 4'd0;
         m_count   = 0;
         return;
      end
      ev      = (kw != m_prev) && (kw != 4'd0) && (kw < 4'd10);
      m_pulse = 1'b0;
      if (m_pending) begin
         if (rdy) begin
            m_pending = 1'b0;
            m_count   = (m_count + 1) % 256;
         end
      end else if (m_armed) begin
         if (ev && kw == 4'd1) begin
            m_deadline = e_now + T;
         end else if (ev) begin
            m_armed   = 1'b0;
            m_pending = 1'b1;
            m_id      = kw;
         end else if (e_now == m_deadline) begin
            m_armed = 1'b0;
            m_pulse = 1'b1;
         end
      end else if (ev && kw == 4'd1) begin
         m_armed    = 1'b1;
         m_deadline = e_now + T;
      end
      m_prev = kw;
   endtask

   task automatic compare_model();
      chk("armed", 32'(armed), 32'(m_armed));
      chk("cmd_valid", 32'(cmd_valid), 32'(m_pending));
      chk("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
      chk("event_count", 32'(event_count), 32'(m_count));
      if (m_pending) chk("cmd_id", 32'(cmd_id), 32'(m_id));
   endtask

   task automatic cyc(input logic [3:0] k, input logic r, input logic rs);
      kw  = k;
      rdy = r;
      rst = rs;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_model();
   endtask

   task automatic do_reset();
      cyc(4'd0, 1'b0, 1'b0);
      cyc(4'd0, 1'b0, 1'b0);
   endtask

   initial begin
      int r;
      int hold;
      logic [3:0] k;

      // 1: reset holds everything at zero, release arms on the held wake word
      for (int i = 0; i < 3; i++) cyc(4'd1, 1'b0, 1'b0);
      chk("rst_armed", 32'(armed), 32'd0);
      chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("rst_cmd_id", 32'(cmd_id), 32'd0);
      chk("rst_pulse", 32'(timeout_pulse), 32'd0);
      chk("rst_count", 32'(event_count), 32'd0);
      cyc(4'd1, 1'b0, 1'b1);
      chk("rel_armed", 32'(armed), 32'd1);

      // 2: wake then command with ready already high
      do_reset();
      for (int i = 0; i < 5; i++) cyc(4'd1, 1'b1, 1'b1);
      cyc(4'd3, 1'b1, 1'b1);
      chk("s2_valid", 32'(cmd_valid), 32'd1);
      chk("s2_id", 32'(cmd_id), 32'd3);
      cyc(4'd3, 1'b1, 1'b1);
      chk("s2_valid_done", 32'(cmd_valid), 32'd0);
      chk("s2_count", 32'(event_count), 32'd1);
      chk("s2_armed", 32'(armed), 32'd0);

      // 3: timeout after exactly T armed cycles
      do_reset();
      for (int i = 0; i < T; i++) begin
         cyc(4'd1, 1'b0, 1'b1);
         chk("s3_armed_window", 32'(armed), 32'd1);
      end
      cyc(4'd1, 1'b0, 1'b1);
      chk("s3_armed_off", 32'(armed), 32'd0);
      chk("s3_pulse", 32'(timeout_pulse), 32'd1);
      cyc(4'd1, 1'b0, 1'b1);
      chk("s3_pulse_once", 32'(timeout_pulse), 32'd0);
      cyc(4'd3, 1'b0, 1'b1);
      cyc(4'd3, 1'b0, 1'b1);
      chk("s3_no_cmd", 32'(cmd_valid), 32'd0);

      // 4: backpressure holds the command while keywords keep changing
      do_reset();
      cyc(4'd1, 1'b0, 1'b1);
      cyc(4'd5, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         cyc(bp_seq[i], 1'b0, 1'b1);
         chk("s4_hold_valid", 32'(cmd_valid), 32'd1);
         chk("s4_hold_id", 32'(cmd_id), 32'd5);
      end
      cyc(4'd7, 1'b1, 1'b1);
      chk("s4_count", 32'(event_count), 32'd1);
      chk("s4_valid_done", 32'(cmd_valid), 32'd0);
      cyc(4'd7, 1'b1, 1'b1);
      chk("s4_idle_armed", 32'(armed), 32'd0);
      chk("s4_single_hs", 32'(event_count), 32'd1);

      // 5: invalid ID ignored, re-arm at timer=2, event on final armed cycle wins
      do_reset();
      cyc(4'd1, 1'b0, 1'b1);
      cyc(4'd12, 1'b0, 1'b1);
      cyc(4'd0, 1'b0, 1'b1);
      chk("s5_invalid_ignored", 32'(cmd_valid), 32'd0);
      chk("s5_still_armed", 32'(armed), 32'd1);
      for (int i = 0; i < 11; i++) cyc(4'd0, 1'b0, 1'b1);
      cyc(4'd1, 1'b0, 1'b1);
      for (int i = 0; i < T - 1; i++) cyc(4'd1, 1'b0, 1'b1);
      chk("s5_rearmed", 32'(armed), 32'd1);
      cyc(4'd4, 1'b0, 1'b1);
      chk("s5_edge_valid", 32'(cmd_valid), 32'd1);
      chk("s5_edge_id", 32'(cmd_id), 32'd4);
      chk("s5_edge_no_pulse", 32'(timeout_pulse), 32'd0);
      cyc(4'd4, 1'b0, 1'b1);
      chk("s5_no_late_pulse", 32'(timeout_pulse), 32'd0);

      // 6: counter wrap, then reset in the middle of an issue
      do_reset();
      for (int n = 0; n < 256; n++) begin
         cyc(4'd0, 1'b1, 1'b1);
         cyc(4'd1, 1'b1, 1'b1);
         cyc(4'd2, 1'b1, 1'b1);
         cyc(4'd2, 1'b1, 1'b1);
         if (n == 254) chk("s6_count_255", 32'(event_count), 32'd255);
      end
      chk("s6_wrap", 32'(event_count), 32'd0);
      cyc(4'd0, 1'b1, 1'b1);
      cyc(4'd1, 1'b1, 1'b1);
      cyc(4'd2, 1'b1, 1'b1);
      cyc(4'd2, 1'b1, 1'b1);
      chk("s6_count_1", 32'(event_count), 32'd1);
      cyc(4'd0, 1'b0, 1'b1);
      cyc(4'd1, 1'b0, 1'b1);
      cyc(4'd6, 1'b0, 1'b1);
      chk("s6_pending", 32'(cmd_valid), 32'd1);
      cyc(4'd6, 1'b1, 1'b0);
      chk("s6_rst_valid", 32'(cmd_valid), 32'd0);
      chk("s6_rst_count", 32'(event_count), 32'd0);

      // Randomized traffic with occasional resets
      do_reset();
      for (int s = 0; s < 300; s++) begin
         r = int'($urandom_range(0, 99));
         if (r < 35)      k = 4'd0;
         else if (r < 60) k = 4'd1;
         else if (r < 92) k = 4'($urandom_range(2, 9));
         else             k = 4'($urandom_range(10, 15));
         hold = int'($urandom_range(1, 24));
         for (int h = 0; h < hold; h++)
            cyc(k, ($urandom_range(0, 2) != 0), ($urandom_range(0, 399) != 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/keyword_command_fsm.md
Name: keyword_command_fsm

Overview:
Sits directly downstream of the keyword debouncer and consumes its stable 4-bit keyword ID. It detects new-keyword events and arms on a wake word. The next valid keyword heard within a timeout window is issued as a command over a valid/ready handshake to the action/display logic. It also counts issued commands.

Parameters:
SILENCE_ID, 4'd0, keyword ID meaning "no keyword"; never produces an event
WAKE_ID, 4'd1, keyword ID that arms the block
NUM_KEYWORDS, 10, IDs >= NUM_KEYWORDS are invalid and ignored
TIMEOUT_CYCLES, 50000000, length of the armed window in clk cycles (1 .. 2^TMR_W-1)
TMR_W, 26, timeout counter width

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
keyword_in  input  4  debounced keyword ID from the debouncer
cmd_ready  input  1  consumer accepts cmd_id when high with cmd_valid
cmd_valid  output  1  command pending
cmd_id  output  4  command keyword ID, stable while cmd_valid=1
armed  output  1  high while waiting for a command after the wake word
timeout_pulse  output  1  one-cycle pulse when the armed window expires unused
event_count  output  8  number of completed command handshakes, wraps 255->0

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, prev_kw=SILENCE_ID, timer=0, cmd_valid=0, cmd_id=0, armed=0, timeout_pulse=0, event_count=0. Reset mid-ISSUE drops the pending command with no handshake.
- prev_kw register: loads keyword_in every non-reset cycle.
- event (combinational) = keyword_in != prev_kw AND keyword_in != SILENCE_ID AND keyword_in < NUM_KEYWORDS.
- Repeating the same keyword generates a second event only if another ID (e.g. silence) intervenes.
- Invalid IDs still update prev_kw.
- State IDLE (armed=0):
  - event with keyword_in==WAKE_ID -> ARMED; timer loads TIMEOUT_CYCLES-1.
  - All other events are ignored.
- State ARMED (armed=1):
  - event with WAKE_ID -> timer reloads TIMEOUT_CYCLES-1; stay ARMED.
  - event with any other valid ID -> cmd_id<=keyword_in, cmd_valid<=1 -> ISSUE. cmd_valid is high in the cycle after the detecting edge, so latency is 1 cycle.
  - No event and timer==0 -> IDLE; timeout_pulse=1 for exactly the next cycle. ARMED therefore lasts exactly TIMEOUT_CYCLES cycles.
  - No event and timer!=0 -> timer decrements by 1.
  - Event and timer==0 in the same cycle: the event wins and no timeout is generated.
- State ISSUE (armed=0):
  - cmd_valid=1 and cmd_id are held until a cycle with cmd_ready=1.
  - On the handshake edge: cmd_valid<=0, event_count<=event_count+1 (mod 256), -> IDLE.
  - cmd_ready may already be high when cmd_valid rises; the handshake then completes at the next edge.
  - Events during ISSUE, including WAKE_ID, are dropped. prev_kw keeps tracking.
  - No timer activity in ISSUE.
- cmd_ready while cmd_valid=0 has no effect.
- All outputs are registered. timeout_pulse is never high for 2 consecutive cycles.

Test Plan:
Use override TIMEOUT_CYCLES=16 for all scenarios.
1. Reset: hold rst=0 for 3 cycles with keyword_in=1 -> all outputs 0. Release rst -> event on keyword_in=1 (prev_kw=0) -> armed=1 next cycle.
2. Wake then command: keyword_in 0->1, 5 cycles later 1->3, cmd_ready=1 -> cmd_valid=1 with cmd_id=3 one cycle after the 3 appears. Handshake completes, event_count=1, armed=0.
3. Timeout: keyword_in 0->1 then held -> armed high exactly 16 cycles, then timeout_pulse high 1 cycle, state IDLE. A later keyword_in=3 -> no cmd_valid.
4. Backpressure: command 5 issued with cmd_ready=0 for 10 cycles while keyword_in toggles 5->0->1->7 -> cmd_valid and cmd_id=5 stay stable. After cmd_ready=1 -> one handshake, then IDLE with armed=0.
5. Filtering and re-arm: in ARMED, keyword_in=12 (invalid) then 0 -> no command. WAKE_ID again at timer=2 -> window restarts at 16. Event and timer==0 coincide -> command issued, no timeout_pulse.
6. Wrap and mid-op reset: 256 command handshakes -> event_count returns to 0. Assert rst=0 during ISSUE -> cmd_valid=0 next cycle and event_count=0.
